// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Request/result bundle for the bit-serial subtractor.
//   start : request, honoured only while the engine is idle
//   X, Y  : minuend / subtrahend, captured on the accepting edge
//   D     : difference X - Y mod 2^WIDTH (registered)
//   Bo    : unsigned borrow-out, 1 iff X < Y (registered)
//   busy  : high while an operation is in flight (SHIFT and DONE)
//   done  : one-cycle pulse when D and Bo carry a fresh result
// The master drives the request side; the subtractor is the slave.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] D;
  logic             Bo;
  logic             busy;
  logic             done;

  modport master (
    output start, X, Y,
    input  D, Bo, busy, done
  );

  modport slave (
    input  start, X, Y,
    output D, Bo, busy, done
  );
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial two's-complement subtractor: D = X - Y over WIDTH-bit operands,
// one bit per clock, LSB first, through one full-subtractor cell whose borrow
// is kept in a register between bits.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; discards any operation in flight
//   bus   : serial_subtractor_if.slave (start, X, Y in; D, Bo, busy, done out)
//
// Timing: start accepted at edge E0, bits processed at E1..E_WIDTH, result and
// done visible after E_WIDTH, back to idle after E_WIDTH+1.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Full-subtractor difference bit.
  function automatic logic fs_diff(input logic x, input logic y, input logic b);
    return x ^ y ^ b;
  endfunction

  // Full-subtractor borrow: borrow when x<y, or when x==y and a borrow arrives.
  function automatic logic fs_borrow(input logic x, input logic y, input logic b);
    return (~x & y) | (~(x ^ y) & b);
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_xs;
  logic [WIDTH-1:0]   r_ys;
  logic [WIDTH-1:0]   r_rs;
  logic               r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_d;
  logic               r_bo;
  logic               r_busy;
  logic               r_done;

  logic               w_d_bit;
  logic               w_b_nxt;
  logic [WIDTH-1:0]   w_rs_nxt;
  logic               w_last;

  // The single bit-cell always works on the current LSBs of the operand shifters.
  assign w_d_bit  = fs_diff(r_xs[0], r_ys[0], r_b);
  assign w_b_nxt  = fs_borrow(r_xs[0], r_ys[0], r_b);
  // Result bits enter at the top so after WIDTH shifts bit 0 sits at rs[0].
  assign w_rs_nxt = {w_d_bit, r_rs[WIDTH-1:1]};
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Next-state decode for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand/result shifters, borrow, bit counter and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xs  <= {WIDTH{1'b0}};
      r_ys  <= {WIDTH{1'b0}};
      r_rs  <= {WIDTH{1'b0}};
      r_b   <= 1'b0;
      r_cnt <= {CNT_W{1'b0}};
      r_d   <= {WIDTH{1'b0}};
      r_bo  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_xs  <= bus.X;
            r_ys  <= bus.Y;
            r_rs  <= {WIDTH{1'b0}};
            r_b   <= 1'b0;
            r_cnt <= {CNT_W{1'b0}};
          end
        end
        S_SHIFT: begin
          r_xs  <= {1'b0, r_xs[WIDTH-1:1]};
          r_ys  <= {1'b0, r_ys[WIDTH-1:1]};
          r_rs  <= w_rs_nxt;
          r_b   <= w_b_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          // The MSB edge publishes the finished word; D/Bo then hold until
          // the next completion, even across a new start.
          if (w_last) begin
            r_d  <= w_rs_nxt;
            r_bo <= w_b_nxt;
          end
        end
        default: begin
          r_b <= r_b;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.D    = r_d;
  assign bus.Bo   = r_bo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  serial_subtractor_if #(.WIDTH(4)) b4 ();
  serial_subtractor_if #(.WIDTH(8)) b8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: issue one WIDTH=4 op, push its expectation, wait for done.
  task automatic op4(input logic [3:0] x, input logic [3:0] y,
                     output int lat, output int bcnt, output bit to);
    int n;
    exp_t e;
    logic [3:0] diff;
    lat = 0; bcnt = 0; to = 1'b0; n = 0;
    while (b4.busy === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    b4.X = x; b4.Y = y; b4.start = 1'b1;
    diff = x - y;
    e.d = {4'd0, diff}; e.bo = (x < y);
    q4.push_back(e);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      b4.start = 1'b0;
      b4.X = 4'($urandom); b4.Y = 4'($urandom);
      if (b4.busy === 1'b1) bcnt++;
    end while (b4.done !== 1'b1 && n < 20);
    to = (b4.done !== 1'b1);
    lat = n - 1;
  endtask

  // Stimulus only: issue one WIDTH=8 op, push its expectation, wait for done.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, output bit to);
    int n;
    exp_t e;
    to = 1'b0; n = 0;
    while (b8.busy === 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    b8.X = x; b8.Y = y; b8.start = 1'b1;
    e.d = x - y; e.bo = (x < y);
    q8.push_back(e);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      b8.start = 1'b0;
      b8.X = 8'($urandom); b8.Y = 8'($urandom);
    end while (b8.done !== 1'b1 && n < 30);
    to = (b8.done !== 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    b4.start = 1'b0; b4.X = 4'd0; b4.Y = 4'd0;
    b8.start = 1'b0; b8.X = 8'd0; b8.Y = 8'd0;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({b4.D, b4.Bo, b4.busy, b4.done} !== 7'd0) begin
      bad++; $display("FAIL reset4: D/Bo/busy/done=%b required 0", {b4.D, b4.Bo, b4.busy, b4.done});
    end
    total++;
    if ({b8.D, b8.Bo, b8.busy, b8.done} !== 11'd0) begin
      bad++; $display("FAIL reset8: D/Bo/busy/done=%b required 0", {b8.D, b8.Bo, b8.busy, b8.done});
    end
    b4.start = 1'b1;
    @(posedge clk); #1;
    total++;
    if (b4.busy !== 1'b0) begin
      bad++; $display("FAIL start_in_reset: busy=%b required 0", b4.busy);
    end
    rst_n = 1'b1;
    b4.start = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    bit to;
    exp_t e;
    op4(4'd9, 4'd5, lat, bcnt, to);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout: done=%b required 1", b4.done); end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL basic_latency: %0d required 4", lat); end
    total++;
    if (q4.size() == 0) begin
      bad++; $display("FAIL basic_sb: queue empty, required one entry");
    end else begin
      e = q4.pop_front();
      if (b4.D !== 4'd4 || b4.D !== e.d[3:0] || b4.Bo !== e.bo) begin
        bad++; $display("FAIL basic_result: D=%0d Bo=%b required D=%0d Bo=%b", b4.D, b4.Bo, e.d[3:0], e.bo);
      end
    end
    total++;
    if (bcnt !== 5) begin bad++; $display("FAIL basic_busy_len: %0d required 5", bcnt); end
    @(posedge clk); #1;
    total++;
    if (b4.done !== 1'b0 || b4.busy !== 1'b0) begin
      bad++; $display("FAIL basic_after: done=%b busy=%b required 0 0", b4.done, b4.busy);
    end
  endtask

  task automatic test_borrow();
    logic [3:0] xv[4];
    logic [3:0] yv[4];
    int lat, bcnt;
    bit to;
    exp_t e;
    xv = '{4'd3, 4'd0, 4'd15, 4'd0};
    yv = '{4'd7, 4'd1, 4'd15, 4'd0};
    for (int i = 0; i < 4; i++) begin
      op4(xv[i], yv[i], lat, bcnt, to);
      total++;
      if (to || q4.size() == 0) begin
        bad++; $display("FAIL borrow_done[%0d]: timeout=%b required 0", i, to);
        q4.delete();
      end else begin
        e = q4.pop_front();
        if (b4.D !== e.d[3:0] || b4.Bo !== e.bo) begin
          bad++; $display("FAIL borrow[%0d]: D=%0d Bo=%b required D=%0d Bo=%b", i, b4.D, b4.Bo, e.d[3:0], e.bo);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, cyc, last, ndone;
    logic prev_busy, prev_done;
    exp_t e;
    n = 0;
    while (b4.busy === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    b4.X = 4'd10; b4.Y = 4'd3; b4.start = 1'b1;
    cyc = 0; last = 0; ndone = 0;
    prev_busy = b4.busy; prev_done = b4.done;
    while (ndone < 3 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (b4.busy === 1'b1 && prev_busy === 1'b0) begin
        e.d = 8'd7; e.bo = 1'b0;
        q4.push_back(e);
        b4.X = 4'($urandom); b4.Y = 4'($urandom);
      end
      if (b4.done === 1'b1) begin
        total++;
        if (prev_done === 1'b1) begin bad++; $display("FAIL b2b_done_width: done high 2 cycles, required 1"); end
        total++;
        if (q4.size() == 0) begin
          bad++; $display("FAIL b2b_sb: queue empty, required one entry");
        end else begin
          e = q4.pop_front();
          if (b4.D !== e.d[3:0] || b4.Bo !== e.bo) begin
            bad++; $display("FAIL b2b_result: D=%0d Bo=%b required D=%0d Bo=%b", b4.D, b4.Bo, e.d[3:0], e.bo);
          end
        end
        if (ndone > 0) begin
          total++;
          if (cyc - last !== 6) begin bad++; $display("FAIL b2b_spacing: %0d required 6", cyc - last); end
        end
        last = cyc;
        ndone++;
        b4.X = 4'd10; b4.Y = 4'd3;
        if (ndone == 3) b4.start = 1'b0;
      end
      prev_busy = b4.busy; prev_done = b4.done;
    end
    b4.start = 1'b0;
    total++;
    if (ndone !== 3) begin bad++; $display("FAIL b2b_count: %0d dones required 3", ndone); end
  endtask

  task automatic test_reset_mid();
    int n, ndone, lat, bcnt;
    bit to;
    exp_t e;
    n = 0;
    while (b4.busy === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    b4.X = 4'd6; b4.Y = 4'd2; b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0; b4.X = 4'($urandom); b4.Y = 4'($urandom);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({b4.D, b4.Bo, b4.busy, b4.done} !== 7'd0) begin
      bad++; $display("FAIL midreset_clear: D=%0d Bo=%b busy=%b done=%b required 0", b4.D, b4.Bo, b4.busy, b4.done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (b4.done === 1'b1) ndone++;
    end
    total++;
    if (ndone !== 0) begin bad++; $display("FAIL midreset_nodone: %0d dones required 0", ndone); end
    op4(4'd6, 4'd2, lat, bcnt, to);
    total++;
    if (to || q4.size() == 0) begin
      bad++; $display("FAIL midreset_again: timeout=%b required 0", to);
      q4.delete();
    end else begin
      e = q4.pop_front();
      if (b4.D !== 4'd4 || b4.D !== e.d[3:0] || b4.Bo !== e.bo) begin
        bad++; $display("FAIL midreset_again: D=%0d Bo=%b required D=%0d Bo=%b", b4.D, b4.Bo, e.d[3:0], e.bo);
      end
    end
  endtask

  task automatic test_sweep4();
    int lat, bcnt;
    bit to;
    exp_t e;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op4(4'(x), 4'(y), lat, bcnt, to);
        total++;
        if (to || q4.size() == 0) begin
          bad++; $display("FAIL sweep4_done: x=%0d y=%0d timeout=%b required 0", x, y, to);
          q4.delete();
        end else begin
          e = q4.pop_front();
          if (b4.D !== e.d[3:0] || b4.Bo !== e.bo) begin
            bad++; $display("FAIL sweep4: x=%0d y=%0d D=%0d Bo=%b required D=%0d Bo=%b", x, y, b4.D, b4.Bo, e.d[3:0], e.bo);
          end
        end
      end
    end
  endtask

  task automatic test_sweep8();
    bit to;
    exp_t e;
    logic [7:0] x, y;
    for (int i = 0; i < 104; i++) begin
      case (i)
        0: begin x = 8'd0;   y = 8'd255; end
        1: begin x = 8'd255; y = 8'd0;   end
        2: begin x = 8'd128; y = 8'd128; end
        3: begin x = 8'd0;   y = 8'd1;   end
        default: begin x = 8'($urandom); y = 8'($urandom); end
      endcase
      op8(x, y, to);
      total++;
      if (to || q8.size() == 0) begin
        bad++; $display("FAIL sweep8_done: x=%0d y=%0d timeout=%b required 0", x, y, to);
        q8.delete();
      end else begin
        e = q8.pop_front();
        if (b8.D !== e.d || b8.Bo !== e.bo) begin
          bad++; $display("FAIL sweep8: x=%0d y=%0d D=%0d Bo=%b required D=%0d Bo=%b", x, y, b8.D, b8.Bo, e.d, e.bo);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_reset_mid();
    test_sweep4();
    test_sweep8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing D = X − Y over WIDTH-bit operands, one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the subtract-direction counterpart of the team's ripple-carry full-adder datapath. It trades the parallel ripple chain for a multi-cycle start/busy/done engine, so one bit-cell is reused across all operand bits. Its parallel-in/parallel-out ports let it sit wherever the adder's operand and result buses do.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE; captures X and Y.
- X  input  WIDTH  minuend, sampled on the accepting edge only.
- Y  input  WIDTH  subtrahend, sampled on the accepting edge only.
- D  output  WIDTH  difference X − Y mod 2^WIDTH; registered.
- Bo  output  1  borrow-out: 1 iff X < Y, unsigned; registered.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  single-cycle pulse when D and Bo are valid.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, one bit per cycle.
  - DONE: busy=1, done=1.
- IDLE → SHIFT on a rising edge with start=1. On that edge:
  - Load X into shift register xs and Y into ys.
  - Clear borrow register b and result shift register rs.
  - Bit counter cnt ← 0.
- Each SHIFT edge computes one bit from x0=xs[0] and y0=ys[0]:
  - Difference bit d = x0 ^ y0 ^ b.
  - Next borrow b ← (~x0 & y0) | (~(x0 ^ y0) & b).
  - xs and ys shift right by 1.
  - rs shifts right, with d inserted at rs[WIDTH-1].
  - cnt ← cnt+1.
- SHIFT → DONE on the edge where cnt == WIDTH−1, which processes the MSB. On that same edge:
  - D ← final rs value.
  - Bo ← final borrow.
- DONE → IDLE unconditionally on the next edge.
- start is ignored in SHIFT and DONE. There is no queueing: a request held high through DONE is accepted in the following IDLE cycle.
- X and Y may change freely after the accepting edge without affecting the result.
- D and Bo hold their value from DONE until the next completion. They are not cleared on start.
- cnt width is $clog2(WIDTH).
- No overflow flag. Bo is the unsigned borrow. Signed interpretation of D is the caller's concern.

## Timing
- Reset (rst_n=0, asynchronous, at any time including mid-SHIFT):
  - state=IDLE, D=0, Bo=0, busy=0, done=0.
  - xs, ys, rs, b and cnt cleared.
  - Any in-flight operation is discarded with no done pulse.
- Start accepted at edge E0. Bits are processed at edges E1..E_WIDTH.
- D, Bo, done=1 and busy=1 are all visible after edge E_WIDTH. done falls and busy falls after E_WIDTH+1.
- Latency is WIDTH clocks from accept to done; throughput is one operation per WIDTH+2 clocks.
- The earliest next accept is edge E_WIDTH+2, with start held high.
- busy rises after E0.
- done is never high for more than one cycle.
- rst_n deasserting coincident with start: start is not accepted until the first clk edge with rst_n=1.

## Test plan
- WIDTH=4, X=9, Y=5, start pulse → done exactly 4 cycles after accept; D=4, Bo=0; busy high 5 cycles.
- X=3, Y=7 → D=12 (1100b), Bo=1.
- X=0, Y=1 → D=15, Bo=1; then X=15, Y=15 → D=0, Bo=0; then X=0, Y=0 → D=0, Bo=0.
- Start held high continuously with X=10, Y=3 → back-to-back results D=7, Bo=0, one done per 6 cycles. X/Y changes during SHIFT do not alter D.
- Start with X=6, Y=2, then assert rst_n=0 at the 2nd SHIFT cycle → D=0, Bo=0, busy=0 immediately, no done. Next start with X=6, Y=2 → D=4.
- Exhaustive WIDTH=4 sweep over all 256 X/Y pairs, compared against (X−Y) mod 16 and X<Y. Repeat a random sweep at WIDTH=8.
